// File: rtl/tx_link_sequencer.sv
// tx_link_sequencer: bring-up sequencer and PRBS error-injection scheduler
// for the serializer TX path. Releases divider, 16:4 mux and PRBS resets in
// that order with a per-stage settle time, then flags tx_ready and drives
// inj_error (single-shot on inj_single rising edge, or every inj_period cycles).
// Ports: clk/rst (async active-high); en run level; cfg_*_cyc stage settle
// counts; inj_mode/inj_single/inj_period injection control; rst_div/rst_mux/
// rst_prbs stage resets; inj_error strobe; tx_ready; seq_state FSM state.
// Optional macro TX_INJ_CNT_EN adds inj_count[15:0], a saturating count of
// inj_error cycles, cleared on each PRBS->RUN transition.
module tx_link_sequencer #(
  parameter int CW = 8,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] cfg_div_cyc,
  input  logic [CW-1:0] cfg_mux_cyc,
  input  logic [CW-1:0] cfg_prbs_cyc,
  input  logic [1:0]    inj_mode,
  input  logic          inj_single,
  input  logic [PW-1:0] inj_period,
  output logic          rst_div,
  output logic          rst_mux,
  output logic          rst_prbs,
  output logic          inj_error,
  output logic          tx_ready,
`ifdef TX_INJ_CNT_EN
  output logic [15:0]   inj_count,
`endif
  output logic [2:0]    seq_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DIV  = 3'd1,
    S_MUX  = 3'd2,
    S_PRBS = 3'd3,
    S_RUN  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [PW-1:0] pcnt, pcnt_nxt;
  logic [PW:0]   pcnt_inc;
  logic          single_q;
  logic [1:0]    mode_q;
  logic [PW-1:0] period_q;
  logic          inj_nxt;
  logic          run_stay;
  logic          cfg_chg;
  logic          settled;

  // A dwell count of 0 or 1 both mean "leave after this cycle".
  assign settled = (cnt == '0) || (cnt == CW'(1));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (en) begin
          state_nxt = S_DIV;
          cnt_nxt   = cfg_div_cyc;
        end
      end
      S_DIV: begin
        if (!en) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (settled) begin
          state_nxt = S_MUX;
          cnt_nxt   = cfg_mux_cyc;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_MUX: begin
        if (!en) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (settled) begin
          state_nxt = S_PRBS;
          cnt_nxt   = cfg_prbs_cyc;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_PRBS: begin
        if (!en) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (settled) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_RUN: begin
        if (!en) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Injection only fires on edges where RUN is both the current and next
  // state, so leaving RUN clears inj_error on the same edge as tx_ready.
  assign run_stay = (state == S_RUN) && en;
  assign cfg_chg  = (inj_mode != mode_q) || (inj_period != period_q);
  assign pcnt_inc = {1'b0, pcnt} + (PW+1)'(1);

  always_comb begin
    inj_nxt  = 1'b0;
    pcnt_nxt = '0;
    if (run_stay) begin
      case (inj_mode)
        2'd1: inj_nxt = inj_single & ~single_q;
        2'd2: begin
          // A mode/period change restarts the interval from zero.
          if (!cfg_chg && (inj_period != '0)) begin
            if (pcnt_inc == {1'b0, inj_period}) begin
              inj_nxt = 1'b1;
            end else begin
              pcnt_nxt = pcnt_inc[PW-1:0];
            end
          end
        end
        default: inj_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pcnt      <= '0;
      single_q  <= 1'b0;
      mode_q    <= '0;
      period_q  <= '0;
      rst_div   <= 1'b1;
      rst_mux   <= 1'b1;
      rst_prbs  <= 1'b1;
      inj_error <= 1'b0;
      tx_ready  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pcnt      <= pcnt_nxt;
      single_q  <= inj_single;
      mode_q    <= inj_mode;
      period_q  <= inj_period;
      // Resets are decoded from the next state so each output is registered
      // and the release order follows the state order.
      rst_div   <= (state_nxt == S_IDLE);
      rst_mux   <= (state_nxt == S_IDLE) || (state_nxt == S_DIV);
      rst_prbs  <= (state_nxt == S_IDLE) || (state_nxt == S_DIV) || (state_nxt == S_MUX);
      inj_error <= inj_nxt;
      tx_ready  <= (state_nxt == S_RUN);
    end
  end

  assign seq_state = state;

`ifdef TX_INJ_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_count <= '0;
    end else if ((state == S_PRBS) && (state_nxt == S_RUN)) begin
      inj_count <= '0;
    end else if (inj_nxt && (inj_count != 16'hFFFF)) begin
      inj_count <= inj_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tx_link_sequencer.sv
// tb_tx_link_sequencer: directed and randomized stimulus for tx_link_sequencer,
// checked every cycle against a reference model that derives the expected
// outputs from the number of consecutive enabled cycles since IDLE.
module tb_tx_link_sequencer;
  localparam int CW = 8;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [CW-1:0] cfg_div_cyc, cfg_mux_cyc, cfg_prbs_cyc;
  logic [1:0]    inj_mode;
  logic          inj_single;
  logic [PW-1:0] inj_period;
  logic          rst_div, rst_mux, rst_prbs, inj_error, tx_ready;
  logic [2:0]    seq_state;
`ifdef TX_INJ_CNT_EN
  logic [15:0]   inj_count;
`endif

  tx_link_sequencer #(.CW(CW), .PW(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cfg_div_cyc  (cfg_div_cyc),
    .cfg_mux_cyc  (cfg_mux_cyc),
    .cfg_prbs_cyc (cfg_prbs_cyc),
    .inj_mode     (inj_mode),
    .inj_single   (inj_single),
    .inj_period   (inj_period),
    .rst_div      (rst_div),
    .rst_mux      (rst_mux),
    .rst_prbs     (rst_prbs),
    .inj_error    (inj_error),
    .tx_ready     (tx_ready),
`ifdef TX_INJ_CNT_EN
    .inj_count    (inj_count),
`endif
    .seq_state    (seq_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: 'up' counts consecutive enabled edges since IDLE (capped
  // at the RUN threshold). Stage boundaries follow from the dwell times.
  int            up, dd, dm, dp, edge_n, anchor, m_cnt;
  logic          m_inj, m_single_q;
  logic [1:0]    m_mode_q;
  logic [PW-1:0] m_per_q;

  function automatic int max1(input logic [CW-1:0] v);
    return (v == 0) ? 1 : int'(v);
  endfunction

  function automatic int thr();
    return 1 + dd + dm + dp;
  endfunction

  task automatic model_reset();
    up = 0; dd = 1; dm = 1; dp = 1; edge_n = 0; anchor = 0; m_cnt = 0;
    m_inj = 1'b0; m_single_q = 1'b0; m_mode_q = '0; m_per_q = '0;
  endtask

  task automatic model_edge();
    bit pre_run, chg;
    pre_run = (up > 0) && (up >= thr());
    chg = (inj_mode != m_mode_q) || (inj_period != m_per_q);
    edge_n++;
    m_inj = 1'b0;
    if (pre_run && en) begin
      if (inj_mode == 2'd1) m_inj = inj_single && !m_single_q;
      if (inj_mode == 2'd2) begin
        if (chg) anchor = edge_n;
        else if (inj_period != 0) m_inj = ((edge_n - anchor) % int'(inj_period)) == 0;
      end
    end
    if (!en) begin
      up = 0;
    end else begin
      if (up == 0) begin
        dd = max1(cfg_div_cyc); dm = max1(cfg_mux_cyc); dp = max1(cfg_prbs_cyc);
      end
      if (up < thr()) up++;
      if (!pre_run && up == thr()) begin
        anchor = edge_n;
        m_cnt = 0;
      end
    end
    if (m_inj && m_cnt != 16'hFFFF) m_cnt++;
    m_single_q = inj_single; m_mode_q = inj_mode; m_per_q = inj_period;
  endtask

  task automatic check_all();
    int es;
    if (up == 0) es = 0;
    else if (up < 1 + dd) es = 1;
    else if (up < 1 + dd + dm) es = 2;
    else if (up < thr()) es = 3;
    else es = 4;
    chk("rst_div", rst_div, up == 0);
    chk("rst_mux", rst_mux, up < 1 + dd);
    chk("rst_prbs", rst_prbs, up < 1 + dd + dm);
    chk("tx_ready", tx_ready, es == 4);
    chk("seq_state", seq_state, es);
    chk("inj_error", inj_error, m_inj);
`ifdef TX_INJ_CNT_EN
    chk("inj_count", inj_count, m_cnt);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_cfg(input int a, input int b, input int c);
    cfg_div_cyc = CW'(a); cfg_mux_cyc = CW'(b); cfg_prbs_cyc = CW'(c);
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_rst_div", rst_div, 1);
    chk("arst_rst_mux", rst_mux, 1);
    chk("arst_rst_prbs", rst_prbs, 1);
    chk("arst_tx_ready", tx_ready, 0);
    chk("arst_seq_state", seq_state, 0);
    chk("arst_inj_error", inj_error, 0);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; en = 1'b0; inj_mode = 2'd0; inj_single = 1'b0; inj_period = '0;
    set_cfg(2, 3, 4);
    model_reset();
    #3;
    check_all();
    rst = 1'b0;

    // Reference bring-up: 2/3/4 settle counts.
    step(); step();
    en = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      step();
      if (c == 1) chk("ex_div_fall", rst_div, 0);
      if (c == 2) chk("ex_mux_held", rst_mux, 1);
      if (c == 3) chk("ex_mux_fall", rst_mux, 0);
      if (c == 5) chk("ex_prbs_held", rst_prbs, 1);
      if (c == 6) chk("ex_prbs_fall", rst_prbs, 0);
      if (c == 9) chk("ex_not_ready", tx_ready, 0);
      if (c == 10) chk("ex_ready", tx_ready, 1);
    end

    // Zero settle counts: one cycle per stage.
    en = 1'b0; step();
    set_cfg(0, 0, 0);
    en = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 3) chk("zero_not_ready", tx_ready, 0);
      if (c == 4) chk("zero_ready", tx_ready, 1);
    end

    // Single shot with inj_single held for 5 cycles.
    inj_mode = 2'd1; step(); step();
    inj_single = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) chk("single_timing", inj_error, 1);
      pulses += int'(inj_error);
    end
    inj_single = 1'b0; step(); step();
    chk("single_pulses", pulses, 1);

    // Periodic mode, period 4, counted from RUN entry.
    en = 1'b0; inj_mode = 2'd2; inj_period = 16'd4; step();
    en = 1'b1;
    for (int c = 1; c <= 4; c++) step();
    pulses = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (inj_error) pulses++;
      if (c == 4 || c == 20) chk("period_pulse", inj_error, 1);
    end
    chk("period_pulses", pulses, 5);
`ifdef TX_INJ_CNT_EN
    chk("period_count", inj_count, 5);
`endif

    // Drop en while in MUX.
    en = 1'b0; inj_mode = 2'd0; step();
    set_cfg(3, 3, 3);
    en = 1'b1;
    for (int c = 1; c <= 5; c++) step();
    chk("mux_state", seq_state, 2);
    en = 1'b0;
    step();
    chk("drop_state", seq_state, 0);
    chk("drop_rst_div", rst_div, 1);
    chk("drop_inj", inj_error, 0);

    // Async reset mid-RUN, then restart from DIV.
    set_cfg(1, 1, 1); inj_mode = 2'd2; inj_period = 16'd1;
    en = 1'b1;
    for (int c = 1; c <= 6; c++) step();
    chk("pre_rst_ready", tx_ready, 1);
    async_reset();
    @(posedge clk); #1;
    check_all();
    rst = 1'b0;
    step();
    chk("restart_div", seq_state, 1);

    // Randomized phase.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      if (!en) set_cfg($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
      if ($urandom_range(0, 24) == 0) inj_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) inj_period = PW'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) inj_single = ~inj_single;
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
        rst = 1'b0;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
